// File: rtl/muxn_pkg.sv
// Shared constants and helpers for the muxn_delay_pipe block.
//   MUXN_MAX_N     : largest supported input count
//   MUXN_MAX_DELAY : largest supported pipeline depth
//   COUNT_W        : width of the delivered-sample counter
//   clog2()        : ceiling log2, used to size and sanity-check the select
package muxn_pkg;

    localparam int MUXN_MAX_N     = 64;
    localparam int MUXN_MAX_DELAY = 8;
    localparam int COUNT_W        = 16;

    typedef logic [COUNT_W-1:0] count_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/muxn_pipe_stage.sv
// One pipeline stage of muxn_delay_pipe: a (data, valid) register that
// freezes while i_hold is high.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   i_hold     : keep current contents this cycle
//   i_data     : data to capture
//   i_valid    : valid to capture
//   o_data     : registered data
//   o_valid    : registered valid
module muxn_pipe_stage
    import muxn_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_hold,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (!i_hold) begin
            r_data  <= i_data;
            r_valid <= i_valid;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/muxn_delay_pipe.sv
// N-to-1 multiplexer feeding a DELAY-stage registered pipeline with
// valid/ready flow control, out-of-range select flag and delivery counter.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   enable     : 0 injects a bubble instead of accepting in_valid
//   sel        : input select
//   mux_in     : packed inputs, input i = mux_in[i*WIDTH +: WIDTH]
//   in_valid   : upstream sample valid
//   in_ready   : block can accept this cycle (low only while stalled)
//   mux_out    : selected data after DELAY stages
//   out_valid  : mux_out holds a sample
//   out_ready  : downstream accepts mux_out
//   sel_err    : 1-cycle pulse after accepting a beat with sel >= N
//   count      : samples delivered, wraps at 16 bits
// Build option: MUXN_HOLD_LAST_EN makes mux_out hold the last delivered
// value while out_valid is low; otherwise mux_out is 0 then.
module muxn_delay_pipe
    import muxn_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int N     = 8,
    parameter int SEL_W = 3,
    parameter int DELAY = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [SEL_W-1:0]   sel,
    input  logic [N*WIDTH-1:0] mux_in,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   mux_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               sel_err,
    output logic [COUNT_W-1:0] count
);

    // With a power-of-2 input count every select value is in range.
    localparam bit SelAlwaysValid = (N == (1 << clog2(N)));

    logic [WIDTH-1:0] w_sel_data;
    logic             w_sel_oob;
    logic             w_stall;
    logic             w_accept;
    logic             w_deliver;
    logic [WIDTH-1:0] w_stage0_data;
    logic [WIDTH-1:0] w_last_data;
    logic             w_last_valid;

    logic [WIDTH-1:0] w_chain_data  [DELAY];
    logic             w_chain_valid [DELAY];

    logic               r_sel_err;
    logic [COUNT_W-1:0] r_count;

    // Select decode; an unmatched select yields zero data and flags oob.
    always_comb begin
        w_sel_data = '0;
        w_sel_oob  = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (sel == SEL_W'(i)) begin
                w_sel_data = mux_in[i*WIDTH +: WIDTH];
                w_sel_oob  = 1'b0;
            end
        end
        if (SelAlwaysValid) begin
            w_sel_oob = 1'b0;
        end
    end

    assign w_last_data   = w_chain_data[DELAY-1];
    assign w_last_valid  = w_chain_valid[DELAY-1];
    assign w_stall       = w_last_valid & ~out_ready;
    assign w_accept      = in_valid & enable & ~w_stall;
    assign w_deliver     = w_last_valid & out_ready;
    // Bubbles carry zero data so invalid stages never hold stale samples.
    assign w_stage0_data = w_accept ? w_sel_data : '0;

    for (genvar g = 0; g < DELAY; g++) begin : g_stage
        if (g == 0) begin : g_first
            muxn_pipe_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_hold  (w_stall),
                .i_data  (w_stage0_data),
                .i_valid (w_accept),
                .o_data  (w_chain_data[g]),
                .o_valid (w_chain_valid[g])
            );
        end else begin : g_rest
            muxn_pipe_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_hold  (w_stall),
                .i_data  (w_chain_data[g-1]),
                .i_valid (w_chain_valid[g-1]),
                .o_data  (w_chain_data[g]),
                .o_valid (w_chain_valid[g])
            );
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sel_err <= 1'b0;
            r_count   <= '0;
        end else begin
            r_sel_err <= w_accept & w_sel_oob;
            if (w_deliver) begin
                r_count <= r_count + COUNT_W'(1);
            end
        end
    end

`ifdef MUXN_HOLD_LAST_EN
    logic [WIDTH-1:0] r_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last <= '0;
        end else if (w_deliver) begin
            r_last <= w_last_data;
        end
    end

    assign mux_out = w_last_valid ? w_last_data : r_last;
`else
    assign mux_out = w_last_valid ? w_last_data : '0;
`endif

    assign in_ready  = ~w_stall;
    assign out_valid = w_last_valid;
    assign sel_err   = r_sel_err;
    assign count     = r_count;

endmodule

// File: tb/tb_muxn_delay_pipe.sv
// Bench for muxn_delay_pipe: an N=8/WIDTH=1/DELAY=2 instance driven by
// table vectors and hand sequences, and an N=6/WIDTH=8/DELAY=3 instance
// compared every cycle against a queue-based reference model.
module tb_muxn_delay_pipe;

    localparam int D6 = 3;
`ifdef MUXN_HOLD_LAST_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [2:0]  sel;
    logic        in_valid;
    logic        out_ready;
    logic [7:0]  mux_in8;
    logic [47:0] mux_in6;

    logic        in_ready8, out_valid8, sel_err8, mux_out8;
    logic [15:0] count8;
    logic        in_ready6, out_valid6, sel_err6;
    logic [7:0]  mux_out6;
    logic [15:0] count6;

    int nvec  = 0;
    int nfail = 0;
    bit chk6  = 1'b0;

    muxn_delay_pipe #(
        .WIDTH (1), .N (8), .SEL_W (3), .DELAY (2)
    ) dut8 (
        .clk (clk), .rst_n (rst_n), .enable (enable), .sel (sel), .mux_in (mux_in8),
        .in_valid (in_valid), .in_ready (in_ready8), .mux_out (mux_out8),
        .out_valid (out_valid8), .out_ready (out_ready), .sel_err (sel_err8), .count (count8)
    );

    muxn_delay_pipe #(
        .WIDTH (8), .N (6), .SEL_W (3), .DELAY (D6)
    ) dut6 (
        .clk (clk), .rst_n (rst_n), .enable (enable), .sel (sel), .mux_in (mux_in6),
        .in_valid (in_valid), .in_ready (in_ready6), .mux_out (mux_out6),
        .out_valid (out_valid6), .out_ready (out_ready), .sel_err (sel_err6), .count (count6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the pipe is a fixed-length queue of samples that
    // shifts by one whenever the output is not blocked.
    typedef struct {
        bit         v;
        logic [7:0] d;
    } ent_t;

    ent_t       mq[$];
    int         mcount = 0;
    bit         mselerr = 1'b0;
    logic [7:0] mlast = '0;

    task automatic model_step();
        ent_t e;
        bit   acc;
        int   s;
        if (!rst_n) begin
            foreach (mq[i]) begin
                mq[i].v = 1'b0;
                mq[i].d = '0;
            end
            mcount  = 0;
            mselerr = 1'b0;
            mlast   = '0;
        end else begin
            mselerr = 1'b0;
            if (mq[$].v && out_ready) begin
                mcount = (mcount + 1) % 65536;
                mlast  = mq[$].d;
            end
            if (!(mq[$].v && !out_ready)) begin
                s   = int'(sel);
                acc = in_valid && enable;
                e.v = acc;
                e.d = (acc && s < 6) ? mux_in6[s*8 +: 8] : 8'h00;
                mselerr = acc && (s >= 6);
                mq.push_front(e);
                void'(mq.pop_back());
            end
        end
    endtask

    initial begin
        ent_t z;
        z.v = 1'b0;
        z.d = '0;
        for (int i = 0; i < D6; i++) mq.push_back(z);
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check6();
        logic [7:0] emo;
        emo = mq[$].v ? mq[$].d : (HOLD ? mlast : 8'h00);
        chk("m6_out_valid", 32'(out_valid6), 32'(mq[$].v));
        chk("m6_mux_out", 32'(mux_out6), 32'(emo));
        chk("m6_sel_err", 32'(sel_err6), 32'(mselerr));
        chk("m6_count", 32'(count6), 32'(mcount));
        chk("m6_in_ready", 32'(in_ready6), 32'(!(mq[$].v && !out_ready)));
    endtask

    task automatic tick();
        @(negedge clk);
        if (chk6) check6();
    endtask

    task automatic drive(input bit iv, input bit en, input logic [2:0] s);
        in_valid = iv;
        enable   = en;
        sel      = s;
    endtask

    typedef struct {
        bit         iv;
        bit         en;
        logic [2:0] sel;
        bit         ev;
        bit         ed;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit iv, bit en, logic [2:0] s, bit ev, bit ed);
        vec_t r;
        r.iv  = iv;
        r.en  = en;
        r.sel = s;
        r.ev  = ev;
        r.ed  = ed;
        return r;
    endfunction

    logic got8[$];
    int   nb;
    bit   hb;

    initial begin
        hb = HOLD;
        // Sweep sel 0..7 over pattern 1010_0110, then flush (output lags 2 edges).
        tbl.push_back(mk(1, 1, 3'd0, 0, 0));
        tbl.push_back(mk(1, 1, 3'd1, 1, 0));
        tbl.push_back(mk(1, 1, 3'd2, 1, 1));
        tbl.push_back(mk(1, 1, 3'd3, 1, 1));
        tbl.push_back(mk(1, 1, 3'd4, 1, 0));
        tbl.push_back(mk(1, 1, 3'd5, 1, 0));
        tbl.push_back(mk(1, 1, 3'd6, 1, 1));
        tbl.push_back(mk(1, 1, 3'd7, 1, 0));
        tbl.push_back(mk(0, 1, 3'd0, 1, 1));
        tbl.push_back(mk(0, 1, 3'd0, 0, hb));
        // enable low for two cycles mid-stream -> two bubbles.
        tbl.push_back(mk(1, 1, 3'd1, 0, hb));
        tbl.push_back(mk(1, 1, 3'd2, 1, 1));
        tbl.push_back(mk(1, 0, 3'd3, 1, 1));
        tbl.push_back(mk(1, 0, 3'd3, 0, hb));
        tbl.push_back(mk(1, 1, 3'd5, 0, hb));
        tbl.push_back(mk(1, 1, 3'd7, 1, 1));
        tbl.push_back(mk(0, 1, 3'd0, 1, 1));
        tbl.push_back(mk(0, 1, 3'd0, 0, hb));

        mux_in8   = 8'b1010_0110;
        mux_in6   = 48'h0102_0304_0506;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        drive(1, 1, 3'd3);

        // Reset held two cycles with in_valid high.
        tick();
        tick();
        chk("rst_out_valid8", 32'(out_valid8), 0);
        chk("rst_mux_out8", 32'(mux_out8), 0);
        chk("rst_count8", 32'(count8), 0);
        chk("rst_sel_err8", 32'(sel_err8), 0);
        chk("rst_in_ready8", 32'(in_ready8), 1);
        chk("rst_out_valid6", 32'(out_valid6), 0);
        chk("rst_mux_out6", 32'(mux_out6), 0);
        chk("rst_count6", 32'(count6), 0);
        chk("rst_sel_err6", 32'(sel_err6), 0);
        chk("rst_in_ready6", 32'(in_ready6), 1);
        chk6  = 1'b1;
        rst_n = 1'b1;

        // Table vectors: inputs for row i, outputs checked after its edge.
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].iv, tbl[i].en, tbl[i].sel);
            tick();
            chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid8), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_mux_out", i), 32'(mux_out8), 32'(tbl[i].ed));
            if (i == 9) chk("sweep_count", 32'(count8), 8);
        end

        // Backpressure: out_ready low for cycles 2..4 of a sel 0..3 stream.
        nb = 0;
        got8.delete();
        for (int c = 0; c < 14; c++) begin
            out_ready = !(c >= 2 && c <= 4);
            drive(nb < 4, 1, 3'(nb));
            #1;
            if (c >= 2 && c <= 4) chk($sformatf("bp_in_ready_c%0d", c), 32'(in_ready8), 0);
            if (c == 5) chk("bp_in_ready_resume", 32'(in_ready8), 1);
            if (out_valid8 && out_ready) got8.push_back(mux_out8);
            if (in_valid && in_ready8) nb++;
            tick();
        end
        chk("bp_beats_sent", 32'(nb), 4);
        chk("bp_beats_got", 32'(got8.size()), 4);
        if (got8.size() == 4) begin
            chk("bp_b0", 32'(got8[0]), 0);
            chk("bp_b1", 32'(got8[1]), 1);
            chk("bp_b2", 32'(got8[2]), 1);
            chk("bp_b3", 32'(got8[3]), 0);
        end

        // Out-of-range select on the 6-input instance.
        out_ready = 1'b1;
        drive(0, 1, 3'd0);
        repeat (4) tick();
        drive(1, 1, 3'd7);
        tick();
        chk("oob_sel_err_pulse", 32'(sel_err6), 1);
        drive(0, 1, 3'd0);
        tick();
        chk("oob_sel_err_clear", 32'(sel_err6), 0);
        tick();
        chk("oob_out_valid", 32'(out_valid6), 1);
        chk("oob_mux_out", 32'(mux_out6), 0);
        tick();
        chk("oob_out_valid_gone", 32'(out_valid6), 0);

        // Randomized traffic against the model, with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst_n     = ($urandom % 200) != 0;
            out_ready = ($urandom % 3) != 0;
            mux_in6   = {16'($urandom), $urandom};
            drive(($urandom % 4) != 0, ($urandom % 5) != 0, 3'($urandom));
            tick();
        end

        // Counter wrap: 65534 beats then three more, one at a time.
        rst_n = 1'b0;
        drive(0, 1, 3'd1);
        out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        drive(1, 1, 3'd1);
        repeat (65534) tick();
        drive(0, 1, 3'd1);
        repeat (3) tick();
        chk("cnt_fffe", 32'(count8), 32'h0000_FFFE);
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 3'd2);
            tick();
            drive(0, 1, 3'd2);
            repeat (3) tick();
            chk($sformatf("cnt_wrap%0d", k), 32'(count8), 32'((16'hFFFF + k) % 65536));
        end

        // Reset during a stall empties the pipe.
        out_ready = 1'b0;
        drive(1, 1, 3'd5);
        repeat (4) tick();
        chk("stall_in_ready", 32'(in_ready8), 0);
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        drive(0, 1, 3'd0);
        tick();
        chk("rst_stall_count", 32'(count8), 0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_stall_empty%0d", k), 32'(out_valid8), 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
